// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad button conditioner.
package keypad_pkg;

  typedef enum logic [1:0] {BTN_W, BTN_E, BTN_S, BTN_N} btn_code_t;

  localparam int unsigned IDX_N = 3;
  localparam int unsigned IDX_S = 2;
  localparam int unsigned IDX_E = 1;
  localparam int unsigned IDX_W = 0;

  typedef enum logic {ARMED, HELD} cond_state_t;

  // Highest-priority set bit, N > S > E > W.
  function automatic btn_code_t prio_code(input logic [3:0] r);
    if (r[IDX_N])      return BTN_N;
    else if (r[IDX_S]) return BTN_S;
    else if (r[IDX_E]) return BTN_E;
    else               return BTN_W;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-channel conditioner: 2-FF synchronizer followed by a stability counter.
module btn_debounce #(
  parameter int STABLE_CNT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_db
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s1;
  logic             s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= btn;
      s  <= s1;
    end
  end

  // Any return to the accepted level restarts the count, so short glitches never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (s == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      btn_db <= s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_btn_conditioner.sv
// Debounces N/S/E/W and emits one press event per press with first-press lockout.
// Optional release pulse enabled by defining BTN_RELEASE_PULSE_EN.
module keypad_btn_conditioner
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ    = 125_000_000,
  parameter int STABLE_TIME = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic [3:0] btn_db,
  output logic       press_vld,
  output logic [1:0] press_code,
  output logic       busy,
  output logic       rel_vld,
  output logic [1:0] rel_code
);

  localparam int STABLE_RAW = CLK_FREQ / 1000 * STABLE_TIME;
  localparam int STABLE_CNT = (STABLE_RAW < 1) ? 1 : STABLE_RAW;

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.STABLE_CNT(STABLE_CNT)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn    (btn[i]),
      .btn_db (btn_db[i])
    );
  end

  logic [3:0]  btn_db_q;
  logic [3:0]  rise;
  cond_state_t state;
  cond_state_t state_next;
  btn_code_t   held_code;
  logic        accept;
  logic        release_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_db_q <= '0;
    else        btn_db_q <= btn_db;
  end

  assign rise = btn_db & ~btn_db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARMED;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARMED:   if (|rise) state_next = HELD;
      HELD:    if (btn_db == 4'b0000) state_next = ARMED;
      default: state_next = ARMED;
    endcase
  end

  // Rises seen while HELD (including the exit cycle) are dropped by construction.
  always_comb begin
    accept     = 1'b0;
    release_ev = 1'b0;
    case (state)
      ARMED:   accept     = |rise;
      HELD:    release_ev = (btn_db == 4'b0000);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_vld <= 1'b0;
      held_code <= BTN_W;
    end else begin
      press_vld <= accept;
      if (accept) held_code <= prio_code(rise);
    end
  end

  assign press_code = held_code;
  assign busy       = (state == HELD);

`ifdef BTN_RELEASE_PULSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_vld  <= 1'b0;
      rel_code <= '0;
    end else begin
      rel_vld  <= release_ev;
      rel_code <= release_ev ? held_code : 2'd0;
    end
  end
`else
  logic unused_rel;
  assign unused_rel = release_ev;
  assign rel_vld    = 1'b0;
  assign rel_code   = '0;
`endif

endmodule

// File: tb/tb_keypad_btn_conditioner.sv
// Directed bench for keypad_btn_conditioner with STABLE_CNT=16.
module tb_keypad_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] btn_db;
  logic       press_vld;
  logic [1:0] press_code;
  logic       busy;
  logic       rel_vld;
  logic [1:0] rel_code;

  keypad_btn_conditioner #(.CLK_FREQ(16_000), .STABLE_TIME(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .btn_db     (btn_db),
    .press_vld  (press_vld),
    .press_code (press_code),
    .busy       (busy),
    .rel_vld    (rel_vld),
    .rel_code   (rel_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Event monitor sampled on the falling edge.
  int         pulses = 0;
  int         consec = 0;
  int         rels   = 0;
  logic [1:0] last_code = 2'd0;
  logic [1:0] last_rel  = 2'd0;
  logic       prev_vld  = 1'b0;

  always @(negedge clk) begin
    if (press_vld) begin
      pulses++;
      last_code = press_code;
      if (prev_vld) consec++;
    end
    if (rel_vld) begin
      rels++;
      last_rel = rel_code;
    end
    prev_vld = press_vld;
  end

  typedef struct {
    logic [3:0] b;
    int         hold;
    int         gap;
    int         exp_n;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[8];

  task automatic drive(input logic [3:0] b, input int n);
    btn = b;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p0;
    int r0;
    int cyc;

    vecs[0] = '{4'b0001, 40, 40, 1, 2'd0};  // W
    vecs[1] = '{4'b0100, 10, 40, 0, 2'd0};  // S glitch
    vecs[2] = '{4'b1010, 40, 40, 1, 2'd3};  // N+E together
    vecs[3] = '{4'b0100, 40, 40, 1, 2'd2};  // S
    vecs[4] = '{4'b0001, 40, 40, 1, 2'd0};  // W
    vecs[5] = '{4'b0010, 40, 40, 1, 2'd1};  // E
    vecs[6] = '{4'b0001, 40, 40, 1, 2'd0};  // W
    vecs[7] = '{4'b0110,  8, 40, 0, 2'd0};  // S+E glitch

    btn   = 4'b0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset btn_db", int'(btn_db), 0);
    check("reset press_vld", int'(press_vld), 0);
    check("reset busy", int'(busy), 0);
    check("reset rel_vld", int'(rel_vld), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency of a single W press and of busy after release.
    p0  = pulses;
    btn = 4'b0001;
    cyc = 0;
    while (!btn_db[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_range("W db latency", cyc, 18, 19);
    @(negedge clk);
    check("W press_vld", int'(press_vld), 1);
    check("W press_code", int'(press_code), 0);
    check("W busy", int'(busy), 1);
    repeat (20) @(negedge clk);
    btn = 4'b0000;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_range("W busy fall", cyc, 18, 20);
    check("W pulse count", pulses - p0, 1);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      p0 = pulses;
      drive(vecs[i].b, vecs[i].hold);
      drive(4'b0000, vecs[i].gap);
      check($sformatf("vec%0d pulses", i), pulses - p0, vecs[i].exp_n);
      if (vecs[i].exp_n == 1)
        check($sformatf("vec%0d code", i), int'(last_code), int'(vecs[i].exp_code));
      check($sformatf("vec%0d busy", i), int'(busy), 0);
      check($sformatf("vec%0d btn_db", i), int'(btn_db), 0);
    end

    // N+E held, E released and re-pressed while N stays down.
    p0 = pulses;
    drive(4'b1010, 40);
    drive(4'b1000, 30);
    drive(4'b1010, 30);
    drive(4'b0000, 40);
    check("NE repress pulses", pulses - p0, 1);
    check("NE repress code", int'(last_code), 3);

    // Overlapping S then E: one event, busy until E releases.
    p0 = pulses;
    r0 = rels;
    drive(4'b0100, 30);
    drive(4'b0110, 30);
    drive(4'b0010, 30);
    check("SE busy while E held", int'(busy), 1);
    check("SE btn_db E only", int'(btn_db), 2);
    drive(4'b0000, 40);
    check("SE pulses", pulses - p0, 1);
    check("SE code", int'(last_code), 2);
    check("SE busy end", int'(busy), 0);
`ifdef BTN_RELEASE_PULSE_EN
    check("SE rel count", rels - r0, 1);
    check("SE rel code", int'(last_rel), 2);
`else
    check("SE rel count", rels - r0, 0);
`endif

    // Reset while HELD with W still down.
    drive(4'b0001, 30);
    check("rst pre busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst btn_db", int'(btn_db), 0);
    check("rst busy", int'(busy), 0);
    check("rst press_vld", int'(press_vld), 0);
    repeat (3) @(negedge clk);
    p0    = pulses;
    rst_n = 1'b1;
    cyc   = 0;
    while (!press_vld && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_range("rst repress latency", cyc, 18, 20);
    check("rst repress code", int'(press_code), 0);
    drive(4'b0000, 40);
    check("rst repress pulses", pulses - p0, 1);

    check("no back-to-back press_vld", consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
